fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous Ethernet FIFO. It sits directly upstream of the dual-port FIFO memory and drives that memory's write address and full inputs. It also publishes a Gray-coded write pointer for the read-domain controller. It brings the read domain's Gray pointer into the write clock domain through a two-flop synchroniser, and from that pointer it derives full, almost-full, overflow and fill level.

## Interface
Parameters:
- MEM_DEPTH, 64, FIFO entries; power of two, >= 4
- ADDR_BITS, $clog2(MEM_DEPTH), memory address width
- ALMOST_FULL_THRESH, MEM_DEPTH-4, fill level at which o_almost_full asserts

Ports:
- i_clk  in  1  write-domain clock; all logic is on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_wr_en  in  1  write request from the upstream MAC receive path
- i_rd_ptr_gray  in  ADDR_BITS+1  read pointer, Gray coded, from the read clock domain (asynchronous to i_clk)
- o_wr_addr  out  ADDR_BITS  write address to the FIFO memory
- o_wr_ptr_gray  out  ADDR_BITS+1  registered Gray write pointer, sent to the read domain
- o_full  out  1  FIFO full; also drives the memory's full input
- o_almost_full  out  1  fill level >= ALMOST_FULL_THRESH
- o_overflow  out  1  one-cycle pulse when a write is requested while full
- o_wr_level  out  ADDR_BITS+1  write-side fill level, 0..MEM_DEPTH

## Operation
- Accept condition: wr_accept = i_wr_en && !o_full.
- Binary pointer wr_bin is ADDR_BITS+1 bits wide.
  - On accept, wr_bin_next = wr_bin + 1, wrapping modulo 2*MEM_DEPTH. Otherwise wr_bin_next = wr_bin.
  - o_wr_addr = wr_bin[ADDR_BITS-1:0], taken from the register with no combinational path from i_wr_en.
- Gray conversion: o_wr_ptr_gray is registered as wr_bin_next ^ (wr_bin_next >> 1). Consecutive values differ in exactly one bit.
- Synchroniser: i_rd_ptr_gray passes through sync1 then sync2, each a full-width register. No logic sits between the two stages.
- rd_bin_sync is the Gray-to-binary conversion of sync2: bit[n] = XOR of sync2[ADDR_BITS:n].
- Full: o_full is registered as (gray(wr_bin_next) == {~sync2[ADDR_BITS:ADDR_BITS-1], sync2[ADDR_BITS-2:0]}).
- Level: o_wr_level is registered as wr_bin_next - rd_bin_sync, computed modulo 2*MEM_DEPTH.
- Almost full: o_almost_full is registered as (wr_bin_next - rd_bin_sync) >= ALMOST_FULL_THRESH.
- Overflow: o_overflow is registered as i_wr_en && o_full. A write attempted while full is dropped: no pointer change, no memory write.
- The level is pessimistic: it never under-reports occupancy, so full is never missed.

## Timing
- Reset: all registers clear asynchronously on i_reset high; release takes effect at the next i_clk edge.
  - Reset values: o_wr_addr=0, o_wr_ptr_gray=0, o_full=0, o_almost_full=0, o_overflow=0, o_wr_level=0, sync1=sync2=0.
- Write latency: a write accepted at edge N moves o_wr_addr, o_wr_ptr_gray, o_wr_level and flags at edge N.
  - The memory captures data at o_wr_addr as it was before edge N.
- Full assertion: o_full rises on the same edge that accepts the MEM_DEPTH-th outstanding write. A request in the next cycle is already blocked.
- Full release: a change on i_rd_ptr_gray reaches sync2 after 2 edges and o_full/o_wr_level after 3 edges.
- Simultaneous events: a write and a read-pointer update in the same cycle are both applied. The level reflects the new write and the read pointer currently in sync2.
- Wrap-around: wr_bin goes from 2*MEM_DEPTH-1 to 0 with no glitch; o_wr_addr goes from MEM_DEPTH-1 to 0.
- Reset mid-burst: pointers return to 0 immediately and any in-flight write is lost. The read-domain controller must be reset in the same event.

## Test plan
- Fill: reset, i_rd_ptr_gray=0, i_wr_en held high for 64 cycles (defaults).
  - o_full=1 on the 64th accept edge.
  - o_wr_addr=0, o_wr_ptr_gray=7'b1100000, o_wr_level=64.
- Overflow: from the full state, i_wr_en=1 for 3 cycles.
  - o_overflow high for exactly those 3 cycles.
  - o_wr_addr, o_wr_ptr_gray and o_wr_level unchanged.
- Read release: from full, set i_rd_ptr_gray=7'b0000001.
  - o_full falls on the 3rd edge; o_wr_level=63 on the same edge.
  - A write on the next cycle is accepted and o_full re-asserts.
- Almost full: reset, then 59 writes gives o_almost_full=0; the 60th write gives o_almost_full=1 with o_wr_level=60.
- Wrap and Gray integrity: 300 writes with i_rd_ptr_gray tracking the write pointer delayed 4 cycles.
  - o_full is never asserted.
  - Every o_wr_ptr_gray transition flips exactly 1 bit.
  - o_wr_addr wraps 63 to 0 four times.
- Async reset: assert i_reset mid-cycle during a burst at level 20.
  - All outputs reach 0 before the next edge.
  - The first write after release goes to address 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side pointer and flag controller for the asynchronous Ethernet FIFO.
// Keeps the binary write pointer, publishes its Gray-coded form to the read
// domain, and brings the read domain's Gray pointer into this clock domain
// through a two-flop synchroniser. Full, almost-full, overflow and the fill
// level are all derived from that synchronised read pointer.
//
// Ports:
//   i_clk          write-domain clock (rising edge)
//   i_reset        asynchronous, active-high reset
//   i_wr_en        write request from the upstream MAC receive path
//   i_rd_ptr_gray  Gray read pointer from the read clock domain (async)
//   o_wr_addr      write address to the FIFO memory (registered)
//   o_wr_ptr_gray  registered Gray write pointer for the read domain
//   o_full         FIFO full; also gates the memory write
//   o_almost_full  fill level >= ALMOST_FULL_THRESH
//   o_overflow     one-cycle pulse for a write requested while full
//   o_wr_level     write-side fill level, 0..MEM_DEPTH
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int MEM_DEPTH          = 64,
    parameter int ADDR_BITS          = $clog2(MEM_DEPTH),
    parameter int ALMOST_FULL_THRESH = MEM_DEPTH - 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS:0]   i_rd_ptr_gray,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [ADDR_BITS:0]   o_wr_ptr_gray,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic                 o_overflow,
    output logic [ADDR_BITS:0]   o_wr_level
);

    localparam int PW = ADDR_BITS + 1;
    localparam logic [ADDR_BITS:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

    // Registered state
    logic [ADDR_BITS:0] wr_bin_q,  wr_bin_d;
    logic [ADDR_BITS:0] wr_gray_q, wr_gray_d;
    logic               full_q,    full_d;
    logic               almost_full_q, almost_full_d;
    logic               overflow_q, overflow_d;
    logic [ADDR_BITS:0] wr_level_q, wr_level_d;
    logic [ADDR_BITS:0] sync1_q,   sync1_d;
    logic [ADDR_BITS:0] sync2_q,   sync2_d;

    // Combinational helpers
    logic               wr_accept;
    logic [ADDR_BITS:0] rd_bin_sync;
    logic [ADDR_BITS:0] full_gray_match;

    // Gray-to-binary of the synchronised read pointer: each binary bit is the
    // XOR of all Gray bits at and above it.
    generate
        for (genvar gi = 0; gi <= ADDR_BITS; gi++) begin : g_gray2bin
            assign rd_bin_sync[gi] = ^sync2_q[ADDR_BITS:gi];
        end
    endgenerate

    // The FIFO is full when the write pointer is exactly one lap ahead of the
    // read pointer. In Gray code that means the top two bits are inverted and
    // the remaining bits are equal.
    assign full_gray_match = {~sync2_q[ADDR_BITS:ADDR_BITS-1], sync2_q[ADDR_BITS-2:0]};

    always_comb begin
        wr_accept     = i_wr_en && !full_q;
        wr_bin_d      = wr_accept ? (wr_bin_q + PW'(1)) : wr_bin_q;
        wr_gray_d     = wr_bin_d ^ (wr_bin_d >> 1);
        // Two back-to-back flops with no logic between them.
        sync1_d       = i_rd_ptr_gray;
        sync2_d       = sync1_q;
        // Flags look at the pointer after this cycle's write so that full rises
        // on the same edge that accepts the last free slot. The read pointer is
        // the stale synchronised one, which can only over-report occupancy.
        full_d        = (wr_gray_d == full_gray_match);
        wr_level_d    = wr_bin_d - rd_bin_sync;
        almost_full_d = (wr_level_d >= AF_THRESH);
        // A request while full is dropped and reported here instead.
        overflow_d    = i_wr_en && full_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_bin_q      <= '0;
            wr_gray_q     <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_level_q    <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
        end else begin
            wr_bin_q      <= wr_bin_d;
            wr_gray_q     <= wr_gray_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            wr_level_q    <= wr_level_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
        end
    end

    // Outputs come straight from flops; no combinational path from i_wr_en.
    assign o_wr_addr     = wr_bin_q[ADDR_BITS-1:0];
    assign o_wr_ptr_gray = wr_gray_q;
    assign o_full        = full_q;
    assign o_almost_full = almost_full_q;
    assign o_overflow    = overflow_q;
    assign o_wr_level    = wr_level_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Self-checking bench for fifo_wr_ctrl with default parameters (depth 64).
// A behavioural model counts accepted writes and tracks the read count that
// the synchroniser delivers two edges late; expected flags are derived from
// the occupancy those counts imply.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LAP   = 2 * DEPTH;
    localparam int AF_TH = DEPTH - 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [AW:0]   i_rd_ptr_gray = '0;
    logic [AW-1:0] o_wr_addr;
    logic [AW:0]   o_wr_ptr_gray;
    logic          o_full;
    logic          o_almost_full;
    logic          o_overflow;
    logic [AW:0]   o_wr_level;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    int m_wr;        // total accepted writes
    int rd_prev1;    // read count sampled at previous edge
    int rd_prev2;    // read count sampled two edges ago
    int m_level;
    bit m_full, m_af, m_ovf;

    always #5 clk = ~clk;

    fifo_wr_ctrl dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_wr_en       (i_wr_en),
        .i_rd_ptr_gray (i_rd_ptr_gray),
        .o_wr_addr     (o_wr_addr),
        .o_wr_ptr_gray (o_wr_ptr_gray),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .o_wr_level    (o_wr_level)
    );

    function automatic logic [AW:0] gray_of(input int cnt);
        int b;
        b = cnt % LAP;
        return (AW+1)'(b ^ (b >> 1));
    endfunction

    function automatic logic [AW+16:0] model_vec();
        return {(AW)'(m_wr % DEPTH), gray_of(m_wr), m_full, m_af, m_ovf, (AW+1)'(m_level), 8'h00};
    endfunction

    function automatic logic [AW+16:0] dut_vec();
        return {o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_overflow, o_wr_level, 8'h00};
    endfunction

    task automatic model_clear();
        m_wr = 0; rd_prev1 = 0; rd_prev2 = 0; m_level = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge and
    // leave time 1 unit after the edge for sampling.
    task automatic step(input bit wr, input int rd_cnt);
        bit acc;
        i_wr_en       = wr;
        i_rd_ptr_gray = gray_of(rd_cnt);
        @(posedge clk);
        acc     = wr && !m_full;
        m_ovf   = wr && m_full;
        if (acc) m_wr++;
        // Occupancy seen by the write side uses the read count two edges old.
        m_level = (m_wr - rd_prev2) % LAP;
        if (m_level < 0) m_level += LAP;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AF_TH);
        rd_prev2 = rd_prev1;
        rd_prev1 = rd_cnt;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_wr_en = 1'b0;
        i_rd_ptr_gray = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_overflow, o_wr_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d gray=%b full=%b af=%b ovf=%b lvl=%0d want all 0",
                     o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_overflow, o_wr_level);
        end
        step(0, 0);
        n_cmp++;
        if ({o_wr_addr, o_wr_ptr_gray, o_full, o_wr_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got addr=%0d gray=%b full=%b lvl=%0d want all 0",
                     o_wr_addr, o_wr_ptr_gray, o_full, o_wr_level);
        end
        $display("test_reset done");
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0);
            n_cmp++;
            if (o_full !== (i == DEPTH - 1)) begin
                n_fail++;
                $display("FAIL fill_full[%0d]: got %b want %b", i, o_full, (i == DEPTH - 1));
            end
            n_cmp++;
            if (o_wr_level !== (AW+1)'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_level[%0d]: got %0d want %0d", i, o_wr_level, i + 1);
            end
        end
        n_cmp++;
        if (o_wr_addr !== 6'd0 || o_wr_ptr_gray !== 7'b1100000) begin
            n_fail++;
            $display("FAIL fill_ptr: got addr=%0d gray=%b want addr=0 gray=1100000", o_wr_addr, o_wr_ptr_gray);
        end
        $display("test_fill done: level=%0d full=%b", o_wr_level, o_full);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            n_cmp++;
            if (o_overflow !== 1'b1) begin
                n_fail++;
                $display("FAIL overflow_pulse[%0d]: got %b want 1", i, o_overflow);
            end
            n_cmp++;
            if (o_wr_addr !== 6'd0 || o_wr_ptr_gray !== 7'b1100000 || o_wr_level !== 7'd64) begin
                n_fail++;
                $display("FAIL overflow_hold[%0d]: got addr=%0d gray=%b lvl=%0d want 0/1100000/64",
                         i, o_wr_addr, o_wr_ptr_gray, o_wr_level);
            end
        end
        step(0, 0);
        n_cmp++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_end: got %b want 0", o_overflow);
        end
        $display("test_overflow done");
    endtask

    task automatic test_read_release();
        for (int e = 1; e <= 3; e++) begin
            step(0, 1);
            n_cmp++;
            if (o_full !== (e < 3)) begin
                n_fail++;
                $display("FAIL release_full[edge %0d]: got %b want %b", e, o_full, (e < 3));
            end
        end
        n_cmp++;
        if (o_wr_level !== 7'd63) begin
            n_fail++;
            $display("FAIL release_level: got %0d want 63", o_wr_level);
        end
        step(1, 1);
        n_cmp++;
        if (o_full !== 1'b1 || o_wr_addr !== 6'd1 || o_wr_level !== 7'd64 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL release_rewrite: got full=%b addr=%0d lvl=%0d ovf=%b want 1/1/64/0",
                     o_full, o_wr_addr, o_wr_level, o_overflow);
        end
        $display("test_read_release done");
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            step(1, 0);
            if (i == 59) begin
                n_cmp++;
                if (o_almost_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL af_59: got %b want 0", o_almost_full);
                end
            end
        end
        n_cmp++;
        if (o_almost_full !== 1'b1 || o_wr_level !== 7'd60) begin
            n_fail++;
            $display("FAIL af_60: got af=%b lvl=%0d want 1/60", o_almost_full, o_wr_level);
        end
        $display("test_almost_full done");
    endtask

    task automatic test_wrap_gray();
        logic [AW:0]   prev_gray;
        logic [AW-1:0] prev_addr;
        int wraps = 0;
        int bad_flip = 0;
        int full_seen = 0;
        int model_bad = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            prev_gray = o_wr_ptr_gray;
            prev_addr = o_wr_addr;
            step(1, (i >= 4) ? i - 4 : 0);
            if ($countones(prev_gray ^ o_wr_ptr_gray) != 1) bad_flip++;
            if (prev_addr == 6'd63 && o_wr_addr == 6'd0) wraps++;
            if (o_full) full_seen++;
            if (dut_vec() !== model_vec()) model_bad++;
        end
        n_cmp++;
        if (full_seen != 0) begin
            n_fail++;
            $display("FAIL wrap_full: got %0d full cycles want 0", full_seen);
        end
        n_cmp++;
        if (bad_flip != 0) begin
            n_fail++;
            $display("FAIL wrap_gray_flip: got %0d non-single-bit transitions want 0", bad_flip);
        end
        n_cmp++;
        if (wraps != 4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 4", wraps);
        end
        n_cmp++;
        if (model_bad != 0) begin
            n_fail++;
            $display("FAIL wrap_model: got %0d cycles differing from model want 0", model_bad);
        end
        $display("test_wrap_gray done: wraps=%0d", wraps);
    endtask

    task automatic test_random();
        int rd_cnt = 0;
        int rd_pct = 50;
        bit wr;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) rd_pct = $urandom_range(5, 95);
            wr = ($urandom_range(0, 99) < 70);
            if (rd_cnt < m_wr && $urandom_range(0, 99) < rd_pct) rd_cnt++;
            step(wr, rd_cnt);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got addr=%0d gray=%b full=%b af=%b ovf=%b lvl=%0d want addr=%0d gray=%b full=%b af=%b ovf=%b lvl=%0d",
                         i, o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_overflow, o_wr_level,
                         m_wr % DEPTH, gray_of(m_wr), m_full, m_af, m_ovf, m_level);
            end
        end
        $display("test_random done: writes=%0d reads=%0d", m_wr, rd_cnt);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0);
        n_cmp++;
        if (o_wr_level !== 7'd20) begin
            n_fail++;
            $display("FAIL async_pre_level: got %0d want 20", o_wr_level);
        end
        i_wr_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_overflow, o_wr_level} !== '0) begin
            n_fail++;
            $display("FAIL async_clear: got addr=%0d gray=%b full=%b af=%b ovf=%b lvl=%0d want all 0",
                     o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_overflow, o_wr_level);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        i_wr_en = 1'b1;
        #1;
        n_cmp++;
        if (o_wr_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL async_first_addr: got %0d want 0", o_wr_addr);
        end
        step(1, 0);
        n_cmp++;
        if (o_wr_addr !== 6'd1 || o_wr_level !== 7'd1) begin
            n_fail++;
            $display("FAIL async_first_write: got addr=%0d lvl=%0d want 1/1", o_wr_addr, o_wr_level);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_almost_full();
        test_wrap_gray();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
